// File: rtl/critical_error_report_arbiter.sv
// Serializes critical-error events from NUM_SRC checkers onto one difftest reporting channel.
// Each source has a one-entry slot that merges repeats. A round-robin grant and a sticky halt flag complete the block.
module critical_error_report_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int COREID_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_SRC-1:0]          io_in_valid,
  input  logic [NUM_SRC-1:0]          io_in_criticalError,
  input  logic [NUM_SRC*COREID_W-1:0] io_in_coreid,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic                        io_out_criticalError,
  output logic [COREID_W-1:0]         io_out_coreid,
  output logic [$clog2(NUM_SRC)-1:0]  io_out_src,
  output logic [CNT_W-1:0]            io_merge_cnt,
  output logic                        io_halt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int MW    = $clog2(NUM_SRC + 1);
  localparam int SUM_W = CNT_W + MW;
  localparam logic [SRC_W:0]   NUM_SRC_L = (SRC_W + 1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);
  localparam logic [SUM_W-1:0] CNT_MAX   = SUM_W'({CNT_W{1'b1}});

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  state_t              state_next;
  logic [NUM_SRC-1:0]  pend;
  logic [NUM_SRC-1:0]  pend_crit;
  logic [COREID_W-1:0] pend_id [NUM_SRC];
  logic [SRC_W-1:0]    rr_ptr;
  logic                any_pend;
  logic                do_grant;
  logic [SRC_W-1:0]    grant_idx;
  logic [NUM_SRC-1:0]  grant_oh;
  logic [NUM_SRC-1:0]  merge;
  logic [MW-1:0]       merge_num;
  logic [SUM_W-1:0]    cnt_sum;
  logic [CNT_W-1:0]    cnt_next;

  assign any_pend     = |pend;
  assign io_out_valid = (state == SEND);

  // Search for the first pending slot, starting at rr_ptr and wrapping around
  always_comb begin
    logic [SRC_W:0] idx;
    logic           found;
    idx       = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (idx >= NUM_SRC_L) idx = idx - NUM_SRC_L;
      if (!found && pend[idx[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          do_grant   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (io_out_ready) begin
          if (any_pend) do_grant = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A slot being granted on this edge takes a new event as a fresh capture, not a merge
  always_comb begin
    grant_oh  = '0;
    merge     = '0;
    merge_num = '0;
    if (do_grant) grant_oh[grant_idx] = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      merge[i]  = io_in_valid[i] & pend[i] & ~grant_oh[i];
      merge_num = merge_num + MW'(merge[i]);
    end
    cnt_sum  = SUM_W'(io_merge_cnt) + SUM_W'(merge_num);
    cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      io_out_criticalError <= 1'b0;
      io_out_coreid        <= '0;
      io_out_src           <= '0;
      io_merge_cnt         <= '0;
      io_halt              <= 1'b0;
    end else begin
      state        <= state_next;
      io_merge_cnt <= cnt_next;
      if (io_out_valid && io_out_ready && io_out_criticalError) io_halt <= 1'b1;
      if (do_grant) begin
        io_out_criticalError <= pend_crit[grant_idx];
        io_out_coreid        <= pend_id[grant_idx];
        io_out_src           <= grant_idx;
        rr_ptr               <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      pend_crit <= '0;
      for (int i = 0; i < NUM_SRC; i++) pend_id[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (io_in_valid[i] && (!pend[i] || grant_oh[i])) begin
          pend[i]      <= 1'b1;
          pend_crit[i] <= io_in_criticalError[i];
          pend_id[i]   <= io_in_coreid[i*COREID_W +: COREID_W];
        end else if (io_in_valid[i]) begin
          pend_crit[i] <= pend_crit[i] | io_in_criticalError[i];
        end else if (grant_oh[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_critical_error_report_arbiter.sv
// Directed bench for critical_error_report_arbiter.
// Stimulus pushes expected events into a queue, and a negedge monitor pops and compares them on each handshake.
module tb_critical_error_report_arbiter;

  localparam int NUM_SRC  = 4;
  localparam int COREID_W = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [NUM_SRC-1:0]          in_valid;
  logic [NUM_SRC-1:0]          in_crit;
  logic [NUM_SRC*COREID_W-1:0] in_coreid;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_crit;
  logic [COREID_W-1:0]         out_coreid;
  logic [1:0]                  out_src;
  logic [15:0]                 merge_cnt;
  logic                        halt;

  logic [NUM_SRC-1:0]          sat_valid;
  logic [NUM_SRC-1:0]          sat_crit;
  logic [NUM_SRC*COREID_W-1:0] sat_coreid;
  logic                        sat_out_valid;
  logic                        sat_ready;
  logic                        sat_out_crit;
  logic [COREID_W-1:0]         sat_out_coreid;
  logic [1:0]                  sat_out_src;
  logic [3:0]                  sat_merge_cnt;
  logic                        sat_halt;

  critical_error_report_arbiter #(.NUM_SRC(4), .COREID_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_in_valid(in_valid), .io_in_criticalError(in_crit), .io_in_coreid(in_coreid),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_criticalError(out_crit),
    .io_out_coreid(out_coreid), .io_out_src(out_src), .io_merge_cnt(merge_cnt), .io_halt(halt)
  );

  critical_error_report_arbiter #(.NUM_SRC(4), .COREID_W(8), .CNT_W(4)) dut_sat (
    .clock(clock), .reset_n(reset_n),
    .io_in_valid(sat_valid), .io_in_criticalError(sat_crit), .io_in_coreid(sat_coreid),
    .io_out_valid(sat_out_valid), .io_out_ready(sat_ready), .io_out_criticalError(sat_out_crit),
    .io_out_coreid(sat_out_coreid), .io_out_src(sat_out_src), .io_merge_cnt(sat_merge_cnt),
    .io_halt(sat_halt)
  );

  typedef struct packed {
    logic       crit;
    logic [7:0] coreid;
    logic [1:0] src;
  } event_t;

  event_t exp_q[$];
  int total_checks  = 0;
  int passed_checks = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Every handshake must match the oldest expected event; a handshake with nothing expected is an error
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      event_t got;
      event_t want;
      got = {out_crit, out_coreid, out_src};
      if (exp_q.size() == 0) begin
        total_checks++;
        $display("[TB] FAIL unexpected_event: got crit=%0b coreid=0x%0h src=%0d, expected no event",
                 out_crit, out_coreid, out_src);
      end else begin
        want = exp_q.pop_front();
        check_output("scoreboard_event", 32'(got), 32'(want));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid   = '0;
    in_crit    = '0;
    in_coreid  = '0;
    sat_valid  = '0;
    sat_crit   = '0;
    sat_coreid = '0;
  endtask

  task automatic apply_stimulus(input int s, input logic crit, input logic [7:0] id);
    in_valid[s]          = 1'b1;
    in_crit[s]           = crit;
    in_coreid[s*8 +: 8]  = id;
  endtask

  task automatic apply_sat_stimulus(input int s, input logic crit, input logic [7:0] id);
    sat_valid[s]         = 1'b1;
    sat_crit[s]          = crit;
    sat_coreid[s*8 +: 8] = id;
  endtask

  task automatic expect_event(input logic crit, input logic [7:0] id, input logic [1:0] src);
    exp_q.push_back({crit, id, src});
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    out_ready = 1'b0;
    sat_ready = 1'b0;
    #3;
    check_output("rst_valid",     32'(out_valid),     32'd0);
    check_output("rst_crit",      32'(out_crit),      32'd0);
    check_output("rst_coreid",    32'(out_coreid),    32'd0);
    check_output("rst_src",       32'(out_src),       32'd0);
    check_output("rst_merge_cnt", 32'(merge_cnt),     32'd0);
    check_output("rst_halt",      32'(halt),          32'd0);
    check_output("rst_sat_cnt",   32'(sat_merge_cnt), 32'd0);
    step();
    reset_n = 1'b1;

    // Single event, two-cycle latency, halt afterwards
    apply_reset();
    out_ready = 1'b1;
    apply_stimulus(2, 1'b1, 8'h05);
    expect_event(1'b1, 8'h05, 2'd2);
    step(); clear_inputs();
    check_output("t1_c1_valid", 32'(out_valid), 32'd0);
    check_output("t1_c1_halt",  32'(halt),      32'd0);
    step();
    check_output("t1_c2_valid", 32'(out_valid), 32'd1);
    check_output("t1_c2_src",   32'(out_src),   32'd2);
    step();
    check_output("t1_c3_valid", 32'(out_valid), 32'd0);
    check_output("t1_c3_halt",  32'(halt),      32'd1);
    check_output("t1_queue",    32'(exp_q.size()), 32'd0);

    // All sources at once, back-to-back in index order
    apply_reset();
    out_ready = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      apply_stimulus(s, 1'b0, 8'(16 + s));
      expect_event(1'b0, 8'(16 + s), 2'(s));
    end
    step(); clear_inputs();
    step();
    check_output("t2_c2_src", 32'(out_src), 32'd0);
    step(); step(); step();
    check_output("t2_c5_src",    32'(out_src),    32'd3);
    check_output("t2_c5_coreid", 32'(out_coreid), 32'h13);
    step();
    check_output("t2_c6_valid", 32'(out_valid),     32'd0);
    check_output("t2_merge",    32'(merge_cnt),     32'd0);
    check_output("t2_queue",    32'(exp_q.size()),  32'd0);

    // Merges while the channel is stalled; two slots merge on the same edge
    apply_reset();
    out_ready = 1'b0;
    apply_stimulus(0, 1'b0, 8'h30);
    expect_event(1'b0, 8'h30, 2'd0);
    step(); clear_inputs();
    apply_stimulus(1, 1'b0, 8'h21);
    apply_stimulus(2, 1'b0, 8'h25);
    expect_event(1'b1, 8'h21, 2'd1);
    expect_event(1'b0, 8'h25, 2'd2);
    step(); clear_inputs();
    step();
    apply_stimulus(1, 1'b1, 8'h22);
    apply_stimulus(2, 1'b0, 8'h26);
    step(); clear_inputs();
    check_output("t3_merge_cnt",   32'(merge_cnt),  32'd2);
    check_output("t3_hold_valid",  32'(out_valid),  32'd1);
    check_output("t3_hold_coreid", 32'(out_coreid), 32'h30);
    step(); step();
    check_output("t3_hold_src", 32'(out_src), 32'd0);
    out_ready = 1'b1;
    step();
    check_output("t3_c7_halt", 32'(halt),    32'd0);
    check_output("t3_c7_src",  32'(out_src), 32'd1);
    step(); step();
    check_output("t3_c9_valid", 32'(out_valid),    32'd0);
    check_output("t3_c9_halt",  32'(halt),         32'd1);
    check_output("t3_c9_merge", 32'(merge_cnt),    32'd2);
    check_output("t3_queue",    32'(exp_q.size()), 32'd0);

    // Pointer wraps past source 3; a slot reloaded on its grant edge is fresh
    apply_reset();
    out_ready = 1'b1;
    apply_stimulus(3, 1'b0, 8'h43);
    expect_event(1'b0, 8'h43, 2'd3);
    step(); clear_inputs();
    apply_stimulus(0, 1'b0, 8'h40);
    apply_stimulus(3, 1'b1, 8'h44);
    expect_event(1'b0, 8'h40, 2'd0);
    expect_event(1'b1, 8'h44, 2'd3);
    step(); clear_inputs();
    check_output("t4_c2_src", 32'(out_src), 32'd3);
    step();
    check_output("t4_c3_src", 32'(out_src), 32'd0);
    step();
    check_output("t4_c4_src",    32'(out_src),    32'd3);
    check_output("t4_c4_coreid", 32'(out_coreid), 32'h44);
    step();
    check_output("t4_c5_valid", 32'(out_valid),    32'd0);
    check_output("t4_merge",    32'(merge_cnt),    32'd0);
    check_output("t4_halt",     32'(halt),         32'd1);
    check_output("t4_queue",    32'(exp_q.size()), 32'd0);

    // Asynchronous reset while an event is in flight and others are pending
    apply_reset();
    out_ready = 1'b0;
    apply_stimulus(0, 1'b1, 8'h60);
    apply_stimulus(1, 1'b1, 8'h61);
    apply_stimulus(2, 1'b1, 8'h62);
    step(); clear_inputs();
    step();
    check_output("t5_pre_valid",  32'(out_valid),  32'd1);
    check_output("t5_pre_coreid", 32'(out_coreid), 32'h60);
    #2 reset_n = 1'b0;
    #1;
    check_output("t5_rst_valid",  32'(out_valid),  32'd0);
    check_output("t5_rst_crit",   32'(out_crit),   32'd0);
    check_output("t5_rst_coreid", 32'(out_coreid), 32'd0);
    check_output("t5_rst_src",    32'(out_src),    32'd0);
    check_output("t5_rst_halt",   32'(halt),       32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_output("t5_quiet_valid", 32'(out_valid), 32'd0);
    end
    check_output("t5_queue", 32'(exp_q.size()), 32'd0);

    // Saturation of a 4-bit merge counter with 20 merges on one slot
    apply_reset();
    sat_ready = 1'b0;
    apply_sat_stimulus(0, 1'b0, 8'h50);
    step(); clear_inputs();
    for (int c = 1; c <= 21; c++) begin
      apply_sat_stimulus(1, 1'b0, 8'h51);
      step(); clear_inputs();
      if (c + 1 == 16) check_output("t6_cnt_14", 32'(sat_merge_cnt), 32'd14);
      if (c + 1 == 17) check_output("t6_cnt_15", 32'(sat_merge_cnt), 32'd15);
    end
    step();
    check_output("t6_cnt_sat",  32'(sat_merge_cnt),  32'd15);
    check_output("t6_valid",    32'(sat_out_valid),  32'd1);
    check_output("t6_src",      32'(sat_out_src),    32'd0);
    check_output("t6_coreid",   32'(sat_out_coreid), 32'h50);
    check_output("t6_crit",     32'(sat_out_crit),   32'd0);
    check_output("t6_halt",     32'(sat_halt),       32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
